sub_bytes_engine: RTL

Iterative, area-scalable SubBytes / InvSubBytes unit for the AES round datapath. It accepts a 128-bit state and a per-transaction direction bit over a valid/ready handshake. It substitutes LANES bytes per clock using LANES shared forward/inverse S-box pairs, and returns the result over a second valid/ready handshake. It replaces the purely combinational SubBytes / SubBytesInverse pair wherever S-box area matters more than latency.

---
 rtl/sub_bytes_engine_if.sv | 24 ++
 rtl/sub_bytes_engine.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine_if.sv
// Block-level bus for sub_bytes_engine: input block handshake, result handshake and status.
// Handshake rule for both channels: a transfer happens on a rising clock edge where valid && ready;
// the sender keeps valid and its payload stable until that edge.
interface sub_bytes_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inverse;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    logic [1:0]   dbg_state;

    modport master (
        output in_valid, in_state, in_inverse, out_ready,
        input  in_ready, out_valid, out_state, busy, dbg_state
    );

    modport slave (
        input  in_valid, in_state, in_inverse, out_ready,
        output in_ready, out_valid, out_state, busy, dbg_state
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes / InvSubBytes engine: LANES bytes per cycle through shared forward/inverse
// S-boxes, one 128-bit block per ITERS+1 cycles when the consumer keeps up.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input logic             clock,
    input logic             reset,
    sub_bytes_engine_if.slave bus
);
    localparam int ITERS = (LANES > 0) ? 16 / LANES : 1;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int CHUNK = 8 * LANES;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [127:0]   work_q;
    logic           mode_q;
    logic [127:0]   work_d;
    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK-1:0] chunk_out;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // One inverter serves both directions: inverse affine before it, or forward affine after it.
    function automatic logic [7:0] sbox_shared(input logic [7:0] b, input logic inv);
        logic [7:0] pre;
        logic [7:0] g;
        pre = inv ? (rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05) : b;
        g   = gf_inv(pre);
        return inv ? g : (g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63);
    endfunction

    assign chunk_in = work_q[127 - CHUNK * int'(cnt_q) -: CHUNK];

    always_comb begin
        chunk_out = '0;
        for (int l = 0; l < LANES; l++) begin
            chunk_out[CHUNK - 1 - 8 * l -: 8] = sbox_shared(chunk_in[CHUNK - 1 - 8 * l -: 8], mode_q);
        end
    end

    always_comb begin
        work_d = work_q;
        work_d[127 - CHUNK * int'(cnt_q) -: CHUNK] = chunk_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_state;
                        mode_q  <= bus.in_inverse;
                        cnt_q   <= '0;
                        state_q <= S_SUB;
                    end
                end
                S_SUB: begin
                    work_q <= work_d;
                    if (cnt_q == CW'(ITERS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    // Consuming the result and taking the next block share one edge: no bubble.
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            work_q  <= bus.in_state;
                            mode_q  <= bus.in_inverse;
                            cnt_q   <= '0;
                            state_q <= S_SUB;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_state = work_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;
endmodule
